// File: rtl/imem_loader.sv
// imem_loader: boot-loader that receives a framed byte stream from a host
// link, assembles little-endian 32-bit words and writes them into the
// instruction memory. The core is held in reset while a frame is being
// loaded or after a failed load.
//
// Frame: LEN_LO, LEN_HI, 4*LEN data bytes, XOR checksum of the data bytes.
//
// Host handshake: a byte moves on every rising clk edge where
// in_valid && in_ready are both high. in_valid may be raised or dropped at any
// time; in_ready depends only on the loader state and never on in_valid.
module imem_loader #(
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_write,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    // Idle-timer width: it only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   DEPTH_W    = 16'(DEPTH);

    state_e         state_q, state_d;
    logic [15:0]    len_q, len_d;
    logic [23:0]    word_q, word_d;          // first three bytes of the word in flight
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [15:0]    word_idx_q, word_idx_d;
    logic [7:0]     csum_q, csum_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           write_q, write_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic           in_ready_q, busy_q, done_q, error_q, cpu_rst_n_q;

    logic        xfer;
    logic        in_frame;
    logic [15:0] len_rx;

    // in_ready_q is a registered copy of "state is LEN0..CSUM", so it is the
    // handshake qualifier seen by both sides.
    assign xfer     = in_valid & in_ready_q;
    assign in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    assign len_rx   = {in_data, len_q[7:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, word assembly, checksum, idle timer and write strobe.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        timer_d    = timer_q;
        write_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        if (in_frame) begin
            timer_d = xfer ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                    csum_d     = 8'd0;
                    timer_d    = '0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    if (len_rx > DEPTH_W) begin
                        state_d = S_ERR;
                    end else if (len_rx == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = in_data;
                        2'd1: word_d[15:8]  = in_data;
                        2'd2: word_d[23:16] = in_data;
                        default: begin
                            // Word complete: write it next cycle while the
                            // link keeps streaming into the next word.
                            write_d    = 1'b1;
                            data_d     = {in_data, word_q};
                            addr_d     = 32'(word_idx_q);
                            word_idx_d = word_idx_q + 16'd1;
                            if (word_idx_q == len_q - 16'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Host went silent for too long; a byte arriving in the last cycle wins.
        if (in_frame && !xfer && (timer_q == TIMER_LAST)) begin
            state_d = S_ERR;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= 16'd0;
            word_q     <= 24'd0;
            byte_idx_q <= 2'd0;
            word_idx_q <= 16'd0;
            csum_q     <= 8'd0;
            timer_q    <= '0;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
        end else begin
            len_q      <= len_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            timer_q    <= timer_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                           (state_d == S_DATA) || (state_d == S_CSUM);
            busy_q      <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                           (state_d == S_DATA) || (state_d == S_CSUM);
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
            cpu_rst_n_q <= (state_d == S_IDLE);
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_write = write_q;
    assign imem_addr  = addr_q;
    assign imem_data  = data_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed byte streams into imem_loader and checks the
// imem write stream against an expected queue of {addr, data} entries.
module tb_imem_loader;

    localparam int DEPTH   = 128;
    localparam int TIMEOUT = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ERR  = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        imem_write;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  dbg_state;

    imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_write (imem_write),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  frame_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every imem write must match the head of the expected queue.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (imem_write === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) check_eq("wr_unexpected", {imem_addr, imem_data}, '1);
            else check_eq("wr_addr_data", {imem_addr, imem_data}, exp_q.pop_front());
        end
    end

    // Driver tasks; all of them return at posedge + 1.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) idle($urandom_range(0, 3));
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 100) begin
                check_eq("send_stall", {63'd0, in_ready}, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_range(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) send_byte(frame_q[i], gaps);
    endtask

    // Two-word example frame; its data bytes XOR to 0x90.
    task automatic build_t2(input logic [7:0] csum, input bit push_exp);
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00, csum};
        if (push_exp) begin
            exp_q.push_back({32'd0, 32'h0000_0013});
            exp_q.push_back({32'd1, 32'h0010_0093});
        end
    endtask

    task automatic build_random(input int len);
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'd0;
        w  = 32'd0;
        frame_q = {};
        frame_q.push_back(8'(len));
        frame_q.push_back(8'(len >> 8));
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            cs = cs ^ b;
            case (i % 4)
                0: w[7:0]   = b;
                1: w[15:8]  = b;
                2: w[23:16] = b;
                default: begin
                    w[31:24] = b;
                    exp_q.push_back({32'(i / 4), w});
                end
            endcase
        end
        frame_q.push_back(cs);
    endtask

    // Checks after a frame that should end in done.
    task automatic expect_ok(input string tag, input int d0, input int w0, input int nwords);
        idle(3);
        check_eq({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        check_eq({tag, "_writes"}, 64'(wr_cnt - w0), 64'(nwords));
        check_eq({tag, "_error"}, {63'd0, error}, 64'd0);
        check_eq({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, 64'd1);
        check_eq({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_outs"},
                 {in_ready, imem_write, cpu_rst_n, busy, done, error, imem_addr, imem_data},
                 64'd0);
        check_eq({tag, "_state"}, {61'd0, dbg_state}, {61'd0, ST_IDLE});
    endtask

    initial begin
        int d0;
        int w0;

        // T1: reset values, then cpu_rst_n rises on the first clock after release.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("t1_reset");
        rst_n = 1'b1;
        idle(1);
        check_eq("t1_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
        check_eq("t1_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("t1_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});

        // T2: nominal two-word load.
        build_t2(8'h90, 1'b1);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        check_eq("t2_loading", {61'd0, busy, cpu_rst_n, in_ready}, 64'b101);
        send_range(0, frame_q.size() - 1, 1'b0);
        expect_ok("t2", d0, w0, 2);

        // T3: bad checksum -> both words written, error, core held in reset.
        build_t2(8'h00, 1'b1);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        send_range(0, frame_q.size() - 1, 1'b0);
        idle(3);
        check_eq("t3_done", 64'(done_cnt - d0), 64'd0);
        check_eq("t3_writes", 64'(wr_cnt - w0), 64'd2);
        check_eq("t3_flags", {61'd0, error, cpu_rst_n, in_ready}, 64'b100);
        check_eq("t3_queue", 64'(exp_q.size()), 64'd0);

        // T4: LEN one above DEPTH, then LEN with only the high byte set.
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h81, 1'b0);
        send_byte(8'h00, 1'b0);
        check_eq("t4_len129_err", {63'd0, error}, 64'd1);
        check_eq("t4_len129_state", {61'd0, dbg_state}, {61'd0, ST_ERR});
        pulse_start();
        check_eq("t4_err_cleared", {63'd0, error}, 64'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        check_eq("t4_len256_err", {63'd0, error}, 64'd1);
        idle(2);
        check_eq("t4_writes", 64'(wr_cnt - w0), 64'd0);
        build_t2(8'h90, 1'b1);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        send_range(0, frame_q.size() - 1, 1'b0);
        expect_ok("t4_reload", d0, w0, 2);

        // T5a: 15 idle cycles are tolerated, the 16th raises the error.
        build_t2(8'h90, 1'b0);
        pulse_start();
        send_range(0, 2, 1'b0);
        idle(15);
        check_eq("t5_stall15", {63'd0, error}, 64'd0);
        idle(1);
        check_eq("t5_stall16", {63'd0, error}, 64'd1);

        // T5b: a byte arriving in the last allowed cycle keeps the frame alive.
        build_t2(8'h90, 1'b1);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        send_range(0, 2, 1'b0);
        idle(15);
        send_byte(frame_q[3], 1'b0);
        check_eq("t5_late_byte", {63'd0, error}, 64'd0);
        send_range(4, frame_q.size() - 1, 1'b0);
        expect_ok("t5_late", d0, w0, 2);

        // T6a: empty image.
        frame_q = '{8'h00, 8'h00, 8'h00};
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        send_range(0, 2, 1'b0);
        expect_ok("t6_len0", d0, w0, 0);

        // T6b: same two-word frame with random valid gaps.
        build_t2(8'h90, 1'b1);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        send_range(0, frame_q.size() - 1, 1'b1);
        expect_ok("t6_gaps", d0, w0, 2);

        // T6c: full-depth image with random contents.
        build_random(DEPTH);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        send_range(0, frame_q.size() - 1, 1'b0);
        expect_ok("t6_full", d0, w0, DEPTH);

        // T6d: reset in the middle of the second word.
        build_t2(8'h90, 1'b0);
        exp_q.push_back({32'd0, 32'h0000_0013});
        pulse_start();
        send_range(0, 6, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_values("t6_midreset");
        idle(2);
        rst_n = 1'b1;
        w0 = wr_cnt;
        in_valid = 1'b1;
        in_data  = 8'h55;
        idle(10);
        in_valid = 1'b0;
        check_eq("t6_post_reset_writes", 64'(wr_cnt - w0), 64'd0);
        check_eq("t6_post_reset_state", {60'd0, cpu_rst_n, dbg_state}, {60'd0, 1'b1, ST_IDLE});
        check_eq("t6_post_reset_queue", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so a stuck run still reports.
    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
